// File: rtl/instr_fetch_pkg.sv
// Shared fetch-side parameters.
//   ADDR_WIDTH       - PC / address width
//   INSTR_WIDTH      - instruction width
//   ICACHE_BLK_INSTR - instructions per iCache block (power of 2)
//   OPCODE_JAL       - major opcode of RV32 JAL
package instr_fetch_pkg;
   localparam int ADDR_WIDTH       = 32;
   localparam int INSTR_WIDTH      = 32;
   localparam int ICACHE_BLK_INSTR = 16;
   localparam logic [6:0] OPCODE_JAL = 7'b1101111;
endpackage

// File: rtl/instr_fetch_jal_predict.sv
// Static JAL detection and target computation (combinational).
// Shared with the decoder.
//   pc_i     - PC of the instruction
//   instr_i  - instruction word
//   is_jal_o - instruction is a JAL
//   target_o - pc_i + J-immediate (modulo 2^32)
module instr_fetch_jal_predict
   import instr_fetch_pkg::*;
(
   input  logic [ADDR_WIDTH-1:0]  pc_i,
   input  logic [INSTR_WIDTH-1:0] instr_i,
   output logic                   is_jal_o,
   output logic [ADDR_WIDTH-1:0]  target_o
);
   logic [ADDR_WIDTH-1:0] imm;
   logic                  unused_rd;

   // Destination register field plays no part in the target.
   assign unused_rd = ^instr_i[11:7];

   assign is_jal_o = (instr_i[6:0] == OPCODE_JAL);
   assign imm      = {{(ADDR_WIDTH-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
   assign target_o = pc_i + imm;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage behind the iCache.
// Presents pc to the iCache every cycle, pushes hits into the instruction
// queue, requests block refills on a miss, predicts JALs taken, and takes
// ROB redirects.
//   clk, rst_in (sync, active high), rdy_in (low = freeze)
//   icache_ain/icache_hit/icache_instr - iCache lookup
//   mem_req/mem_req_addr/mem_done      - block refill handshake
//   iq_full, iq_out_en, iq_instr, iq_pc, iq_pred_jump - queue push
//   flush_in/flush_pc                  - redirect
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [ADDR_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
   parameter int                    BLK_INSTR = ICACHE_BLK_INSTR
) (
   input  logic                   clk,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   output logic [ADDR_WIDTH-1:0]  icache_ain,
   input  logic                   icache_hit,
   input  logic [INSTR_WIDTH-1:0] icache_instr,
   output logic                   mem_req,
   output logic [ADDR_WIDTH-1:0]  mem_req_addr,
   input  logic                   mem_done,
   input  logic                   iq_full,
   output logic                   iq_out_en,
   output logic [INSTR_WIDTH-1:0] iq_instr,
   output logic [ADDR_WIDTH-1:0]  iq_pc,
   output logic                   iq_pred_jump,
   input  logic                   flush_in,
   input  logic [ADDR_WIDTH-1:0]  flush_pc
);
   typedef enum logic {FETCH, MISS_WAIT} state_e;

   localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ADDR_WIDTH'(BLK_INSTR*4-1);

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic                   mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
   logic                   iq_en_q, iq_en_d;
   logic [INSTR_WIDTH-1:0] iq_instr_q, iq_instr_d;
   logic [ADDR_WIDTH-1:0]  iq_pc_q, iq_pc_d;
   logic                   iq_pj_q, iq_pj_d;

   logic                   is_jal;
   logic [ADDR_WIDTH-1:0]  jal_target;
   logic [ADDR_WIDTH-1:0]  next_pc;

   instr_fetch_jal_predict u_jal (
      .pc_i     (pc_q),
      .instr_i  (icache_instr),
      .is_jal_o (is_jal),
      .target_o (jal_target)
   );

   assign next_pc = is_jal ? jal_target : pc_q + ADDR_WIDTH'(4);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      iq_en_d    = 1'b0;
      iq_instr_d = iq_instr_q;
      iq_pc_d    = iq_pc_q;
      iq_pj_d    = iq_pj_q;
      if (rdy_in) begin
         unique case (state_q)
            FETCH: begin
               if (flush_in) begin
                  pc_d = flush_pc;
               end else if (icache_hit) begin
                  // iq_full already leaves room for the entry landing next cycle.
                  if (!iq_full) begin
                     iq_en_d    = 1'b1;
                     iq_instr_d = icache_instr;
                     iq_pc_d    = pc_q;
                     iq_pj_d    = is_jal;
                     pc_d       = next_pc;
                  end
               end else begin
                  mem_req_d  = 1'b1;
                  mem_addr_d = pc_q & ~BLK_MASK;
                  state_d    = MISS_WAIT;
               end
            end
            MISS_WAIT: begin
               // The controller cannot abort, so a flush only retargets pc;
               // the stale refill still completes and the lookup retries.
               if (flush_in) pc_d = flush_pc;
               if (mem_done) begin
                  mem_req_d = 1'b0;
                  state_d   = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         iq_en_q    <= 1'b0;
         iq_instr_q <= '0;
         iq_pc_q    <= '0;
         iq_pj_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         iq_en_q    <= iq_en_d;
         iq_instr_q <= iq_instr_d;
         iq_pc_q    <= iq_pc_d;
         iq_pj_q    <= iq_pj_d;
      end
   end

   assign icache_ain   = pc_q;
   assign mem_req      = mem_req_q;
   assign mem_req_addr = mem_addr_q;
   assign iq_out_en    = iq_en_q;
   assign iq_instr     = iq_instr_q;
   assign iq_pc        = iq_pc_q;
   assign iq_pred_jump = iq_pj_q;
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst_in, rdy_in;
   logic [31:0] icache_ain;
   logic        icache_hit;
   logic [31:0] icache_instr;
   logic        mem_req;
   logic [31:0] mem_req_addr;
   logic        mem_done, iq_full, iq_out_en;
   logic [31:0] iq_instr, iq_pc;
   logic        iq_pred_jump, flush_in;
   logic [31:0] flush_pc;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        pj;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   instr_fetch #(.RESET_PC(32'h0), .BLK_INSTR(16)) dut (
      .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
      .icache_ain(icache_ain), .icache_hit(icache_hit), .icache_instr(icache_instr),
      .mem_req(mem_req), .mem_req_addr(mem_req_addr), .mem_done(mem_done),
      .iq_full(iq_full), .iq_out_en(iq_out_en), .iq_instr(iq_instr),
      .iq_pc(iq_pc), .iq_pred_jump(iq_pred_jump),
      .flush_in(flush_in), .flush_pc(flush_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_push(input logic [31:0] instr, input logic [31:0] pc, input logic pj);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      e.pj    = pj;
      exp_q.push_back(e);
   endtask

   // Monitor: every push the DUT presents is matched against the scoreboard.
   always @(negedge clk) begin
      if (iq_out_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_push: got pc %h instr %h expected no push", iq_pc, iq_instr);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("push_instr", iq_instr, e.instr);
            chk("push_pc", iq_pc, e.pc);
            chk("push_pred", {31'b0, iq_pred_jump}, {31'b0, e.pj});
         end
      end
   end

   initial begin
      rst_in = 1; rdy_in = 1; icache_hit = 0; icache_instr = 0;
      mem_done = 0; iq_full = 0; flush_in = 0; flush_pc = 0;
      tick(); tick();
      chk("rst_ain", icache_ain, 32'h0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst_mem_addr", mem_req_addr, 32'h0);
      chk("rst_iq_en", {31'b0, iq_out_en}, 32'h0);
      chk("rst_iq_pc", iq_pc, 32'h0);
      rst_in = 0;

      // Plain hit at pc 0.
      icache_hit = 1; icache_instr = 32'h0000_0013; expect_push(32'h13, 32'h0, 1'b0);
      tick();
      chk("hit_ain", icache_ain, 32'h4);

      // Redirect to 0x100, then JAL -8.
      icache_hit = 0; flush_in = 1; flush_pc = 32'h100;
      tick();
      flush_in = 0;
      chk("flush_ain", icache_ain, 32'h100);
      icache_hit = 1; icache_instr = 32'hFF9F_F06F; expect_push(32'hFF9F_F06F, 32'h100, 1'b1);
      tick();
      chk("jal_ain", icache_ain, 32'hF8);

      // Miss at 0x1234.
      icache_hit = 0; flush_in = 1; flush_pc = 32'h1234;
      tick();
      flush_in = 0;
      tick();
      chk("miss_req", {31'b0, mem_req}, 32'h1);
      chk("miss_addr", mem_req_addr, 32'h1200);
      icache_hit = 1; // ignored while waiting
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("miss_hold_req", {31'b0, mem_req}, 32'h1);
         chk("miss_hold_addr", mem_req_addr, 32'h1200);
      end
      icache_hit = 0; mem_done = 1;
      tick();
      mem_done = 0;
      chk("done_req", {31'b0, mem_req}, 32'h0);
      chk("done_ain", icache_ain, 32'h1234);
      icache_hit = 1; icache_instr = 32'h0010_0093; expect_push(32'h0010_0093, 32'h1234, 1'b0);
      tick();
      chk("refill_ain", icache_ain, 32'h1238);

      // Miss at 0x1238, flush to 0x80 mid-wait.
      icache_hit = 0;
      tick();
      chk("miss2_addr", mem_req_addr, 32'h1200);
      flush_in = 1; flush_pc = 32'h80;
      tick();
      flush_in = 0;
      chk("mw_flush_ain", icache_ain, 32'h80);
      chk("mw_flush_req", {31'b0, mem_req}, 32'h1);
      tick(); tick();
      chk("mw_flush_hold", {31'b0, mem_req}, 32'h1);
      mem_done = 1;
      tick();
      mem_done = 0;
      chk("stale_done_req", {31'b0, mem_req}, 32'h0);
      tick();
      chk("remiss_req", {31'b0, mem_req}, 32'h1);
      chk("remiss_addr", mem_req_addr, 32'h80);
      mem_done = 1;
      tick();
      mem_done = 0;
      chk("remiss_done", {31'b0, mem_req}, 32'h0);

      // Backpressure at 0x80.
      icache_hit = 1; icache_instr = 32'h13; iq_full = 1;
      tick();
      chk("full_ain1", icache_ain, 32'h80);
      tick();
      chk("full_ain2", icache_ain, 32'h80);
      iq_full = 0; expect_push(32'h13, 32'h80, 1'b0);
      tick();
      chk("unfull_ain", icache_ain, 32'h84);
      // Flush beats a coincident hit.
      flush_in = 1; flush_pc = 32'h200;
      tick();
      flush_in = 0;
      chk("flush_hit_ain", icache_ain, 32'h200);

      // Pause during consecutive hits.
      expect_push(32'h13, 32'h200, 1'b0);
      tick();
      expect_push(32'h13, 32'h204, 1'b0);
      tick();
      rdy_in = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("pause_ain", icache_ain, 32'h208);
         chk("pause_iq_en", {31'b0, iq_out_en}, 32'h0);
      end
      rdy_in = 1; expect_push(32'h13, 32'h208, 1'b0);
      tick();
      expect_push(32'h13, 32'h20C, 1'b0);
      tick();
      chk("resume_ain", icache_ain, 32'h210);

      // Reset mid-miss.
      icache_hit = 0;
      tick();
      chk("miss3_addr", mem_req_addr, 32'h200);
      rst_in = 1;
      tick();
      rst_in = 0;
      chk("rst_mw_req", {31'b0, mem_req}, 32'h0);
      chk("rst_mw_ain", icache_ain, 32'h0);
      chk("rst_mw_iq_en", {31'b0, iq_out_en}, 32'h0);
      rst_in = 1;
      tick(); tick();
      chk("scoreboard_drained", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage, directly downstream of the iCache. It holds the PC and presents it to the iCache every cycle. On a hit it pushes the instruction and its PC into the instruction queue. On a miss it requests a block refill from the memory controller and waits; the iCache fills on the controller's done pulse. It also performs static JAL target computation and accepts redirects (flush) from the ROB.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
BLK_INSTR, 16, instructions per iCache block (power of 2); the block byte mask is BLK_INSTR*4-1

Ports:
clk  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global ready; low freezes the block
icache_ain  out  32  fetch address, combinational copy of pc
icache_hit  in  1  iCache hit for icache_ain, same cycle
icache_instr  in  32  instruction at icache_ain, valid when icache_hit
mem_req  out  1  block refill request, level, registered
mem_req_addr  out  32  block-aligned refill address, registered
mem_done  in  1  one-cycle pulse; iCache is written on this same edge
iq_full  in  1  instruction queue cannot accept an entry next cycle
iq_out_en  out  1  one-cycle push strobe, registered
iq_instr  out  32  pushed instruction
iq_pc  out  32  PC of pushed instruction
iq_pred_jump  out  1  pushed instruction is a JAL, predicted taken
flush_in  in  1  redirect from ROB (mispredict or exception)
flush_pc  in  32  redirect target

Behaviour:
- Reset (rst_in=1 at posedge):
  - pc<=RESET_PC, state<=FETCH.
  - mem_req<=0, mem_req_addr<=0.
  - iq_out_en<=0, iq_instr<=0, iq_pc<=0, iq_pred_jump<=0.
  - Reset has priority over all other inputs, including in MISS_WAIT.
  - A reset mid-miss abandons the request; the memory controller is reset by the same signal.
- rdy_in=0 with rst_in=0: all registers hold, except iq_out_en<=0 (no push while paused).
- icache_ain=pc at all times.
- Default every cycle: iq_out_en<=0.
- State FETCH, first matching rule applies:
  - flush_in: pc<=flush_pc; no push; stay FETCH.
  - icache_hit && !iq_full: push. iq_out_en<=1, iq_instr<=icache_instr, iq_pc<=pc. pc<=next_pc.
  - icache_hit && iq_full: hold pc; no push.
  - !icache_hit: mem_req<=1, mem_req_addr<=pc & ~(BLK_INSTR*4-1), state<=MISS_WAIT.
- next_pc and iq_pred_jump:
  - If icache_instr[6:0]==7'b1101111 (JAL): next_pc = pc + sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}), and iq_pred_jump<=1.
  - Otherwise: next_pc = pc+4, iq_pred_jump<=0.
  - All PC arithmetic is 32-bit modulo 2^32; wrap-around is silent.
- State MISS_WAIT:
  - mem_req and mem_req_addr are held stable until mem_done.
  - flush_in: pc<=flush_pc. The outstanding request is NOT cancelled; the controller cannot abort.
  - mem_done: mem_req<=0, state<=FETCH. If flush_in and mem_done coincide, both actions apply.
  - After returning to FETCH, the lookup restarts on the current pc. If the block arrived for a stale (pre-flush) pc, the current pc may miss again and issue a new request.
  - icache_hit is ignored in MISS_WAIT.
- Latency:
  - Hit to push: 1 cycle (push visible the cycle after the lookup).
  - Miss to request: 1 cycle.
  - mem_done to first re-lookup hit: 1 cycle.
  - Sustained throughput: 1 instruction/cycle on consecutive hits.
- iq_full: the queue must assert it while one free slot remains. The entry committed by this cycle's push decision lands next cycle, so no overflow occurs.
- mem_req is never asserted twice without an intervening mem_done or reset.

Decomposition:
- Shared param package (existing include): ADDR_WIDTH, INSTR_WIDTH, ICACHE_BLK_INSTR, and a new OPCODE_JAL constant.
- The FETCH/MISS_WAIT state encoding is local.
- Natural sub-module: jal_predict. It is combinational: takes pc and instr, outputs is_jal and target. It is reused later by the decoder.

Test Plan:
- Reset, then hit at pc=0 with instr 32'h00000013, iq_full=0 -> next cycle iq_out_en=1, iq_pc=0, iq_pred_jump=0; icache_ain=4.
- Hit at pc=0x100 with JAL 32'hFF9FF06F (imm=-8) -> iq_pred_jump=1; icache_ain=0xF8 the following cycle.
- Miss at pc=0x1234 (BLK_INSTR=16) -> next cycle mem_req=1, mem_req_addr=0x1200; held across 20 cycles; mem_done pulse -> mem_req=0; a hit on the next lookup pushes iq_pc=0x1234.
- In MISS_WAIT, flush_in with flush_pc=0x80, then mem_done 3 cycles later -> mem_req held until done; the lookup then uses 0x80; a miss there issues mem_req_addr=0x80.
- Hit with iq_full=1 for 2 cycles, then 0 -> no push, pc held; exactly one push when iq_full drops. A flush_in coinciding with a hit -> no push, pc=flush_pc.
- rdy_in=0 for 3 cycles during consecutive hits -> no pushes, pc frozen; resumes in order. rst_in mid-MISS_WAIT -> mem_req=0, pc=RESET_PC next cycle.
